// File: rtl/fphub_pkg.sv
// Shared types and constants for the HUB square-root request arbiter.
package fphub_pkg;

  function automatic int unsigned calc_t(input int unsigned m, input int unsigned e);
    return m + e;
  endfunction

  function automatic int unsigned calc_iw(input int unsigned nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Result pattern returned when the watchdog expires; truncated to operand width.
  localparam logic [63:0] QNAN_ALL_ONES = '1;

endpackage

// File: rtl/fphub_sqrt_arbiter_rr.sv
// Combinational round-robin picker: first set request above ptr_i, wrapping at NREQ.
module rr_arbiter
  import fphub_pkg::*;
#(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = calc_iw(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  input  logic            en_i,
  output logic [NREQ-1:0] gnt_c_o,
  output logic [IW-1:0]   gnt_idx_c_o
);

  logic found;

  always_comb begin
    gnt_c_o     = '0;
    gnt_idx_c_o = '0;
    found       = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      int unsigned idx;
      idx = (32'(ptr_i) + k) % NREQ;
      if (en_i && !found && req_i[idx]) begin
        found        = 1'b1;
        gnt_c_o[idx] = 1'b1;
        gnt_idx_c_o  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/fphub_sqrt_arbiter.sv
// Shares one HUB sqrt unit among NREQ requesters: round-robin grant, start/finish
// sequencing, per-operation watchdog and tagged response routing.
module fphub_sqrt_arbiter
  import fphub_pkg::*;
#(
  parameter  int unsigned M       = 23,
  parameter  int unsigned E       = 8,
  parameter  int unsigned NREQ    = 4,
  parameter  int unsigned TIMEOUT = 64,
  localparam int unsigned T       = calc_t(M, E),
  localparam int unsigned IW      = calc_iw(NREQ),
  localparam int unsigned TW      = T + 1
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*TW-1:0]   req_x,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [TW-1:0]        rsp_data,
  output logic                 rsp_special,
  output logic                 rsp_err,
  output logic                 sq_start,
  output logic [TW-1:0]        sq_x,
  input  logic [TW-1:0]        sq_res,
  input  logic                 sq_finish,
  input  logic                 sq_special,
  output logic                 busy,
  output logic                 timeout_seen,
  output logic                 spurious_seen
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     tag_q, tag_d;
  logic [TW-1:0]     op_x_q, op_x_d;
  logic [TW-1:0]     res_q, res_d;
  logic              special_q, special_d;
  logic              err_q, err_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sq_start_q, sq_start_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;
  logic              timeout_seen_q, timeout_seen_d;
  logic              spurious_seen_q, spurious_seen_d;

  logic [NREQ-1:0]   gnt_c;
  logic [IW-1:0]     gnt_idx_c;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .en_i        (state_q == ST_IDLE),
    .gnt_c_o     (gnt_c),
    .gnt_idx_c_o (gnt_idx_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    tag_d           = tag_q;
    op_x_d          = op_x_q;
    res_d           = res_q;
    special_d       = special_q;
    err_d           = err_q;
    cnt_d           = cnt_q;
    timeout_seen_d  = timeout_seen_q;
    spurious_seen_d = spurious_seen_q | (sq_finish && (state_q != ST_WAIT));

    unique case (state_q)
      ST_IDLE: begin
        if (|gnt_c) begin
          op_x_d  = req_x[32'(gnt_idx_c) * TW +: TW];
          tag_d   = gnt_idx_c;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // A finish in the same cycle as expiry is a real result, so it wins.
        if (sq_finish) begin
          res_d     = sq_res;
          special_d = sq_special;
          err_d     = 1'b0;
          state_d   = ST_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          res_d          = TW'(QNAN_ALL_ONES);
          special_d      = 1'b0;
          err_d          = 1'b1;
          timeout_seen_d = 1'b1;
          state_d        = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready[tag_q]) begin
          rr_ptr_d = tag_q;
          state_d  = ST_IDLE;
        end
      end
    endcase

    sq_start_d  = (state_d == ST_ISSUE);
    rsp_valid_d = (state_d == ST_RESP) ? (NREQ'(1) << tag_d) : '0;
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q         <= ST_IDLE;
      rr_ptr_q        <= IW'(NREQ - 1);
      tag_q           <= '0;
      op_x_q          <= '0;
      res_q           <= '0;
      special_q       <= 1'b0;
      err_q           <= 1'b0;
      cnt_q           <= '0;
      sq_start_q      <= 1'b0;
      rsp_valid_q     <= '0;
      busy_q          <= 1'b0;
      timeout_seen_q  <= 1'b0;
      spurious_seen_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      tag_q           <= tag_d;
      op_x_q          <= op_x_d;
      res_q           <= res_d;
      special_q       <= special_d;
      err_q           <= err_d;
      cnt_q           <= cnt_d;
      sq_start_q      <= sq_start_d;
      rsp_valid_q     <= rsp_valid_d;
      busy_q          <= busy_d;
      timeout_seen_q  <= timeout_seen_d;
      spurious_seen_q <= spurious_seen_d;
    end
  end

  assign req_ready     = gnt_c;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = res_q;
  assign rsp_special   = special_q;
  assign rsp_err       = err_q;
  assign sq_start      = sq_start_q;
  assign sq_x          = op_x_q;
  assign busy          = busy_q;
  assign timeout_seen  = timeout_seen_q;
  assign spurious_seen = spurious_seen_q;

endmodule

// File: tb/tb_fphub_sqrt_arbiter.sv
// Directed bench for fphub_sqrt_arbiter with a fixed-latency sqrt unit stand-in.
module tb_fphub_sqrt_arbiter;

  localparam int unsigned M       = 23;
  localparam int unsigned E       = 8;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 64;
  localparam int          LAT_SPC = 4;
  localparam int          LAT_NRM = M + 4;

  logic         clk = 1'b0;
  logic         rst_l = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_x = '0;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready = '0;
  logic [31:0]  rsp_data;
  logic         rsp_special;
  logic         rsp_err;
  logic         sq_start;
  logic [31:0]  sq_x;
  logic [31:0]  sq_res;
  logic         sq_finish;
  logic         sq_special;
  logic         busy;
  logic         timeout_seen;
  logic         spurious_seen;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fphub_sqrt_arbiter #(.M(M), .E(E), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_x         (req_x),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_special   (rsp_special),
    .rsp_err       (rsp_err),
    .sq_start      (sq_start),
    .sq_x          (sq_x),
    .sq_res        (sq_res),
    .sq_finish     (sq_finish),
    .sq_special    (sq_special),
    .busy          (busy),
    .timeout_seen  (timeout_seen),
    .spurious_seen (spurious_seen)
  );

  // Unit stand-in: specials finish 2 cycles after start, normals M+2 cycles.
  function automatic logic is_spc(input logic [31:0] x);
    logic [7:0] ex;
    ex = x[30:23];
    return x[31] || (ex == 8'hFF) || (ex == 8'h00);
  endfunction

  function automatic logic [31:0] unit_res(input logic [31:0] x);
    logic [7:0] ex;
    ex = x[30:23];
    if (x[31] && (x[30:0] != 31'd0)) return 32'hFFFF_FFFF;
    if (ex == 8'hFF || ex == 8'h00) return x;
    case (x)
      32'h3F80_0000: return 32'h3F80_0000;
      32'h4080_0000: return 32'h4000_0000;
      32'h4180_0000: return 32'h4080_0000;
      32'h4110_0000: return 32'h4040_0000;
      32'h3E80_0000: return 32'h3F00_0000;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  logic [31:0] u_x = '0;
  int          u_cnt = 0;
  logic        unit_dead = 1'b0;
  logic        inj_finish = 1'b0;

  assign sq_res     = unit_res(u_x);
  assign sq_special = is_spc(u_x);
  assign sq_finish  = (u_cnt == 1) || inj_finish;

  always @(posedge clk) begin
    if (!rst_l) u_cnt <= 0;
    else if (sq_start && !unit_dead) begin
      u_x   <= sq_x;
      u_cnt <= is_spc(sq_x) ? 2 : int'(M) + 2;
    end else if (u_cnt > 0) u_cnt <= u_cnt - 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] oh(input int r);
    logic [3:0] v;
    v = 4'b0001;
    return v << r;
  endfunction

  task automatic wait_rsp(inout int lat);
    while (rsp_valid == '0 && lat < 200) begin
      @(negedge clk); #1;
      lat++;
    end
  endtask

  // One full operation from an idle arbiter, including the response handshake.
  task automatic do_op(input int r, input logic [31:0] x, input logic [31:0] exp_d,
                       input logic exp_s, input logic exp_e, input int exp_lat);
    int lat;
    @(negedge clk);
    req_x[r*32 +: 32] = x;
    req_valid[r] = 1'b1;
    #1;
    check("req_ready", {60'd0, req_ready}, {60'd0, oh(r)});
    @(negedge clk);
    req_valid[r] = 1'b0;
    #1;
    check("sq_start", {63'd0, sq_start}, 64'd1);
    check("sq_x", {32'd0, sq_x}, {32'd0, x});
    lat = 1;
    wait_rsp(lat);
    check("latency", 64'(lat), 64'(exp_lat));
    check("rsp_valid", {60'd0, rsp_valid}, {60'd0, oh(r)});
    check("rsp_data", {32'd0, rsp_data}, {32'd0, exp_d});
    check("rsp_err", {63'd0, rsp_err}, {63'd0, exp_e});
    if (!exp_e) check("rsp_special", {63'd0, rsp_special}, {63'd0, exp_s});
    rsp_ready[r] = 1'b1;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    check("post_busy", {63'd0, busy}, 64'd0);
    check("post_rsp_valid", {60'd0, rsp_valid}, 64'd0);
  endtask

  initial begin
    logic [31:0] exp3 [4];
    logic        stable;
    int          lat;
    int          w;

    #3 rst_l = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_rsp_valid", {60'd0, rsp_valid}, 64'd0);
    check("rst_sq_start", {63'd0, sq_start}, 64'd0);
    check("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
    rst_l = 1'b1;

    // Special-case operands: zero, negative, NaN
    do_op(0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, LAT_SPC);
    do_op(2, 32'hBF80_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, LAT_SPC);
    do_op(2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, LAT_SPC);
    do_op(3, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, LAT_NRM);

    // All requesters contending, pointer last left on requester 3
    exp3[0] = 32'h4000_0000;
    exp3[1] = 32'h4080_0000;
    exp3[2] = 32'h4040_0000;
    exp3[3] = 32'h3F00_0000;
    @(negedge clk);
    req_x = {32'h3E80_0000, 32'h4110_0000, 32'h4180_0000, 32'h4080_0000};
    rsp_ready = 4'hF;
    req_valid = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
      w = 0;
      while (req_ready == '0 && w < 50) begin
        @(negedge clk); #1;
        w++;
      end
      check("rr_grant", {60'd0, req_ready}, {60'd0, oh(k % 4)});
      @(negedge clk);
      if (k == 4) req_valid = '0;
      #1;
      lat = 1;
      wait_rsp(lat);
      check("rr_latency", 64'(lat), 64'(LAT_NRM));
      check("rr_rsp_valid", {60'd0, rsp_valid}, {60'd0, oh(k % 4)});
      check("rr_rsp_data", {32'd0, rsp_data}, {32'd0, exp3[k % 4]});
    end
    @(negedge clk);
    rsp_ready = '0;
    #1;
    check("rr_idle", {63'd0, busy}, 64'd0);

    // Requester 1 stalls its response; requester 3 waits behind it
    @(negedge clk);
    req_x[32 +: 32] = 32'h3F80_0000;
    req_x[96 +: 32] = 32'h4080_0000;
    req_valid = 4'b1010;
    #1;
    check("stall_grant1", {60'd0, req_ready}, 64'b0010);
    @(negedge clk);
    req_valid[1] = 1'b0;
    #1;
    lat = 1;
    wait_rsp(lat);
    check("stall_rsp_valid", {60'd0, rsp_valid}, 64'b0010);
    check("stall_rsp_data", {32'd0, rsp_data}, 64'h3F80_0000);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rsp_ready = (i == 0) ? 4'b1000 : 4'b0000;
      #1;
      if (rsp_valid !== 4'b0010 || rsp_data !== 32'h3F80_0000 || sq_start !== 1'b0 ||
          req_ready !== 4'b0000) stable = 1'b0;
    end
    check("stall_hold_stable", {63'd0, stable}, 64'd1);
    rsp_ready = 4'b0010;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    check("stall_next_grant3", {60'd0, req_ready}, 64'b1000);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("stall_sq_x3", {32'd0, sq_x}, 64'h4080_0000);
    lat = 1;
    wait_rsp(lat);
    check("stall_rsp3_valid", {60'd0, rsp_valid}, 64'b1000);
    check("stall_rsp3_data", {32'd0, rsp_data}, 64'h4000_0000);
    rsp_ready[3] = 1'b1;
    @(negedge clk);
    rsp_ready = '0;

    // Watchdog: unit never finishes
    unit_dead = 1'b1;
    check("pre_timeout_seen", {63'd0, timeout_seen}, 64'd0);
    do_op(0, 32'h3F80_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, TIMEOUT + 2);
    check("timeout_seen", {63'd0, timeout_seen}, 64'd1);
    unit_dead = 1'b0;

    // Async reset mid-operation, then a stray finish while idle
    @(negedge clk);
    req_x[64 +: 32] = 32'h4080_0000;
    req_valid[2] = 1'b1;
    #1;
    check("wait_grant2", {60'd0, req_ready}, 64'b0100);
    @(negedge clk);
    req_valid = '0;
    repeat (5) @(negedge clk);
    #1;
    check("wait_busy", {63'd0, busy}, 64'd1);
    rst_l = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_sq_x", {32'd0, sq_x}, 64'd0);
    check("arst_timeout_seen", {63'd0, timeout_seen}, 64'd0);
    check("arst_rsp_data", {32'd0, rsp_data}, 64'd0);
    check("arst_rsp_err", {63'd0, rsp_err}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    #1;
    check("pre_spurious", {63'd0, spurious_seen}, 64'd0);
    @(negedge clk);
    inj_finish = 1'b1;
    @(negedge clk);
    inj_finish = 1'b0;
    #1;
    check("spurious_seen", {63'd0, spurious_seen}, 64'd1);
    repeat (3) @(negedge clk);
    #1;
    check("spurious_no_rsp", {60'd0, rsp_valid}, 64'd0);
    check("spurious_idle", {63'd0, busy}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
